// File: rtl/w0rm_core_pkg.sv
// rtl/w0rm_core_pkg.sv - shared constants for the w0rm core fetch front end
// Purpose: PC step, default reset vector and fetch-sequencer state encoding.
// Ports: none (package).
package w0rm_core_pkg;

  localparam int          PC_INCREMENT         = 2;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Sequencer states; kept as plain constants so older blocks can reuse them.
  localparam logic [1:0] RESET = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

endpackage

// File: rtl/w0rm_core_fetch_sequencer_if.sv
// rtl/w0rm_core_fetch_sequencer_if.sv - fetch sequencer bus bundle
// Purpose: groups the redirect, instruction-memory and decode-side signals.
// Ports (master = sequencer):
//   in : redirect_valid, redirect_pc, ifetch_ready, ifetch_data_valid, ifetch_data, decode_stall
//   out: ifetch_req, ifetch_addr, inst_valid, inst_data, inst_pc, flush_out
interface w0rm_core_fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 16
);

  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  ifetch_req;
  logic [ADDR_WIDTH-1:0] ifetch_addr;
  logic                  ifetch_ready;
  logic                  ifetch_data_valid;
  logic [INST_WIDTH-1:0] ifetch_data;
  logic                  decode_stall;
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  flush_out;

  modport master (
    input  redirect_valid, redirect_pc, ifetch_ready, ifetch_data_valid, ifetch_data, decode_stall,
    output ifetch_req, ifetch_addr, inst_valid, inst_data, inst_pc, flush_out
  );

  modport slave (
    output redirect_valid, redirect_pc, ifetch_ready, ifetch_data_valid, ifetch_data, decode_stall,
    input  ifetch_req, ifetch_addr, inst_valid, inst_data, inst_pc, flush_out
  );

endinterface

// File: rtl/w0rm_core_sync_fifo.sv
// rtl/w0rm_core_sync_fifo.sv - small synchronous FIFO with clear and occupancy count
// Purpose: in-order storage used for fetch PC tags and the decoded-instruction buffer.
// Ports: clk, reset_n (async active-low), clear (empties, wins over push/pop),
//        push/push_data, pop, head_data (entry at read pointer), count (occupancy).
module w0rm_core_sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push   = push & (count != CW'(DEPTH));
  assign do_pop    = pop & (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only observed once count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/w0rm_core_fetch_sequencer.sv
// rtl/w0rm_core_fetch_sequencer.sv - program counter and instruction fetch sequencer
// Purpose: issues in-order fetches under a shared credit limit, buffers returned
//          instructions with their PCs for decode, and handles branch redirects.
// Ports: clk, reset_n (async active-low), bus (master modport):
//        redirect_valid/redirect_pc from the branch unit, ifetch_* to instruction
//        memory, inst_*/decode_stall to decode, flush_out to younger stages.
module w0rm_core_fetch_sequencer
  import w0rm_core_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INST_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int                    MAX_OUTSTANDING = 2
) (
  input logic                         clk,
  input logic                         reset_n,
  w0rm_core_fetch_sequencer_if.master bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = ADDR_WIDTH + INST_WIDTH;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         discard_next;
  logic [CW-1:0]         in_flight_after_resp;
  logic [CW-1:0]         tag_count;
  logic [CW-1:0]         buf_count;
  logic [ADDR_WIDTH-1:0] tag_head;
  logic [BW-1:0]         buf_head;
  logic [BW-1:0]         hold;
  logic                  credit_ok;
  logic                  accept;
  logic                  resp;
  logic                  keep;
  logic                  consume;

  // In-flight fetches and buffered instructions share one credit pool, so a
  // response always has a buffer slot waiting for it.
  assign credit_ok = ({1'b0, in_flight} + {1'b0, buf_count}) < (CW + 1)'(MAX_OUTSTANDING);

  assign bus.ifetch_req  = ((state == FETCH) || (state == DRAIN)) & ~bus.redirect_valid & credit_ok;
  assign bus.ifetch_addr = pc;
  assign accept          = bus.ifetch_req & bus.ifetch_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp    = bus.ifetch_data_valid & (in_flight != '0);
  assign keep    = resp & (discard == '0) & ~bus.redirect_valid;
  assign consume = bus.inst_valid & ~bus.decode_stall;

  assign in_flight_after_resp = in_flight - CW'(resp);

  always_comb begin
    discard_next = discard;
    if (bus.redirect_valid)           discard_next = in_flight_after_resp;
    else if (resp && discard != '0)   discard_next = discard - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RESET;
      pc            <= RESET_VECTOR;
      in_flight     <= '0;
      discard       <= '0;
      bus.flush_out <= 1'b0;
    end else begin
      state         <= (state == RESET) ? FETCH : ((discard_next != '0) ? DRAIN : FETCH);
      in_flight     <= in_flight_after_resp + CW'(accept);
      discard       <= discard_next;
      bus.flush_out <= bus.redirect_valid;
      if (bus.redirect_valid) pc <= bus.redirect_pc & ~ADDR_WIDTH'(1);
      else if (accept)        pc <= pc + ADDR_WIDTH'(PC_INCREMENT);
    end
  end

  // Stale tags are not cleared on redirect; they pop as their discarded responses arrive.
  w0rm_core_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (1'b0),
    .push      (accept),
    .push_data (pc),
    .pop       (resp),
    .head_data (tag_head),
    .count     (tag_count)
  );

  w0rm_core_sync_fifo #(.WIDTH(BW), .DEPTH(MAX_OUTSTANDING)) u_inst_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (bus.redirect_valid),
    .push      (keep),
    .push_data ({tag_head, bus.ifetch_data}),
    .pop       (consume),
    .head_data (buf_head),
    .count     (buf_count)
  );

  // Holds the last presented head so inst_pc/inst_data stay stable while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              hold <= '0;
    else if (buf_count != '0)  hold <= buf_head;
  end

  assign bus.inst_valid                 = (buf_count != '0);
  assign {bus.inst_pc, bus.inst_data}   = bus.inst_valid ? buf_head : hold;

  a_resp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
    bus.ifetch_data_valid |-> (in_flight != '0))
    else $error("ifetch response received with no fetch in flight");

  a_tags_match_in_flight: assert property (@(posedge clk) disable iff (!reset_n)
    tag_count == in_flight)
    else $error("PC tag count diverged from in-flight count");

endmodule

// File: tb/tb_w0rm_core_fetch_sequencer.sv
// tb/tb_w0rm_core_fetch_sequencer.sv - directed scoreboard bench for the fetch sequencer
module tb_w0rm_core_fetch_sequencer;

  localparam int AW = 32;
  localparam int IW = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  w0rm_core_fetch_sequencer_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  w0rm_core_fetch_sequencer #(
    .ADDR_WIDTH      (AW),
    .INST_WIDTH      (IW),
    .RESET_VECTOR    (32'h0),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [47:0] exp_q [$];
  logic [31:0] mem_q [$];
  logic [31:0] acc_log [$];
  logic [31:0] model_pc = 32'h0;
  bit          mem_hold = 1'b0;
  bit          prev_redir = 1'b0;
  logic        s_req, s_inst_valid, s_flush;
  logic [31:0] s_addr;
  int          n_acc = 0;
  int          n_cons = 0;
  logic [31:0] first_acc = '0;
  bit          first_acc_armed = 1'b0;
  logic [31:0] first_cons_pc = '0;
  bit          first_cons_armed = 1'b0;
  logic [31:0] a0;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, update scoreboard and memory model,
  // then drive the next memory response 1 ns after the rising edge.
  task automatic tick();
    logic        acc, resp, redir;
    logic [31:0] a;
    logic [47:0] e;
    @(negedge clk);
    s_req        = bus.ifetch_req;
    s_addr       = bus.ifetch_addr;
    s_inst_valid = bus.inst_valid;
    s_flush      = bus.flush_out;
    a     = bus.ifetch_addr;
    acc   = bus.ifetch_req & bus.ifetch_ready;
    resp  = bus.ifetch_data_valid;
    redir = bus.redirect_valid;
    chk("flush_follows_redirect", s_flush, prev_redir);
    if (redir) chk("no_req_on_redirect", s_req, 0);
    if (bus.inst_valid && !bus.decode_stall && !redir) begin
      n_cons++;
      chk("sb_entry_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", bus.inst_pc, e[47:16]);
        chk("inst_data", bus.inst_data, e[15:0]);
      end
      if (first_cons_armed) begin
        first_cons_pc    = bus.inst_pc;
        first_cons_armed = 1'b0;
      end
    end
    if (acc) begin
      chk("fetch_addr_seq", a, model_pc);
      model_pc = a + 32'd2;
      n_acc++;
      acc_log.push_back(a);
      exp_q.push_back({a, mem_word(a)});
      if (first_acc_armed) begin
        first_acc       = a;
        first_acc_armed = 1'b0;
      end
    end
    if (redir) begin
      model_pc = bus.redirect_pc & ~32'd1;
      exp_q.delete();
    end
    prev_redir = redir;
    @(posedge clk);
    #1;
    if (resp && mem_q.size() != 0) mem_q.delete(0);
    if (acc) mem_q.push_back(a);
    bus.ifetch_data_valid = !mem_hold && (mem_q.size() != 0);
    bus.ifetch_data       = (mem_q.size() != 0) ? mem_word(mem_q[0]) : 16'h0;
  endtask

  task automatic drain();
    bus.ifetch_ready = 1'b0;
    repeat (5) tick();
    chk("drained_scoreboard", exp_q.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = '0;
    bus.ifetch_ready      = 1'b1;
    bus.ifetch_data_valid = 1'b0;
    bus.ifetch_data       = '0;
    bus.decode_stall      = 1'b0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ifetch_req", bus.ifetch_req, 0);
    chk("rst_ifetch_addr", bus.ifetch_addr, 32'h0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst_data", bus.inst_data, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_flush_out", bus.flush_out, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Streaming fetch from reset
    tick();
    chk("no_req_in_reset_state", s_req, 0);
    tick();
    chk("first_req", s_req, 1);
    chk("first_addr", s_addr, 32'h0);
    repeat (12) tick();
    chk("stream_progress", n_cons >= 4, 1);

    // Decode stall: credits cap accepted requests at two
    drain();
    bus.decode_stall = 1'b1;
    bus.ifetch_ready = 1'b1;
    n_acc = 0;
    repeat (10) tick();
    chk("stall_accepts", n_acc, 2);
    chk("stall_req_low", s_req, 0);
    chk("stall_inst_valid", s_inst_valid, 1);
    bus.decode_stall = 1'b0;
    n_acc = 0;
    n_cons = 0;
    repeat (8) tick();
    chk("stall_release_consumed", n_cons >= 2, 1);
    chk("fetch_resumed", n_acc > 0, 1);

    // Redirect with two fetches in flight
    drain();
    mem_hold = 1'b1;
    bus.ifetch_ready = 1'b1;
    n_acc = 0;
    repeat (3) tick();
    chk("two_in_flight", n_acc, 2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1001;
    tick();
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    first_cons_armed = 1'b1;
    first_acc_armed  = 1'b1;
    tick();
    chk("redir_flush_pulse", s_flush, 1);
    chk("redir_inst_valid_low", s_inst_valid, 0);
    chk("redir_next_addr", s_addr, 32'h1000);
    tick();
    chk("redir_flush_one_cycle", s_flush, 0);
    repeat (8) tick();
    chk("redir_first_acc", first_acc, 32'h1000);
    chk("redir_first_inst_pc", first_cons_pc, 32'h1000);

    // Redirect colliding with a would-be accept and a response
    drain();
    bus.ifetch_ready = 1'b1;
    tick();
    a0 = s_addr;
    chk("collide_setup_accept", s_req, 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    first_cons_armed   = 1'b1;
    tick();
    chk("collide_pc_not_advanced", s_addr, a0 + 32'd2);
    bus.redirect_valid = 1'b0;
    tick();
    chk("collide_no_discard_req", s_req, 1);
    chk("collide_new_addr", s_addr, 32'h40);
    repeat (6) tick();
    chk("collide_first_inst_pc", first_cons_pc, 32'h40);

    // Redirect wins over a simultaneous consume
    bus.decode_stall = 1'b1;
    repeat (4) tick();
    chk("buffered_before_redirect", bus.inst_valid, 1);
    bus.decode_stall   = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    chk("consume_squashed", s_inst_valid, 0);
    repeat (8) tick();

    // Back-to-back redirects: the second wins
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    bus.redirect_pc    = 32'h300;
    tick();
    bus.redirect_valid = 1'b0;
    first_acc_armed  = 1'b1;
    first_cons_armed = 1'b1;
    repeat (8) tick();
    chk("b2b_first_acc", first_acc, 32'h300);
    chk("b2b_first_inst_pc", first_cons_pc, 32'h300);

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    tick();
    bus.redirect_valid = 1'b0;
    acc_log.delete();
    repeat (6) tick();
    chk("wrap_accept_count", acc_log.size() >= 2, 1);
    if (acc_log.size() >= 2) begin
      chk("wrap_first_addr", acc_log[0], 32'hFFFF_FFFE);
      chk("wrap_second_addr", acc_log[1], 32'h0);
    end

    // Asynchronous reset mid-stream
    reset_n = 1'b0;
    #1;
    chk("async_rst_ifetch_req", bus.ifetch_req, 0);
    chk("async_rst_ifetch_addr", bus.ifetch_addr, 32'h0);
    chk("async_rst_inst_valid", bus.inst_valid, 0);
    chk("async_rst_inst_data", bus.inst_data, 0);
    chk("async_rst_inst_pc", bus.inst_pc, 0);
    chk("async_rst_flush_out", bus.flush_out, 0);
    exp_q.delete();
    mem_q.delete();
    bus.ifetch_data_valid = 1'b0;
    model_pc   = 32'h0;
    prev_redir = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    chk("rerst_no_req", s_req, 0);
    tick();
    chk("rerst_first_req", s_req, 1);
    chk("rerst_first_addr", s_addr, 32'h0);
    repeat (6) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/w0rm_core_fetch_sequencer.md
Name: w0rm_core_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction-fetch requests to instruction memory.
- Buffers returned 16-bit instructions with their PCs for decode.
- Applies redirects from the branch unit: discards in-flight fetches and pulses a flush to downstream stages.
- Sits between instruction memory and decode; the branch unit's next_pc / next_pc_valid drive its redirect inputs.

Parameters:
- ADDR_WIDTH, 32, PC and fetch address width.
- INST_WIDTH, 16, instruction word width; PC advances by 2 per instruction.
- RESET_VECTOR, 0, PC loaded on reset.
- MAX_OUTSTANDING, 2, total fetch credits, shared between in-flight requests and buffered instructions (power of 2, ≥1).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  branch unit next_pc_valid; one-cycle redirect
- redirect_pc  in  ADDR_WIDTH  branch target; bit 0 is ignored (forced 0)
- ifetch_req  out  1  fetch request valid
- ifetch_addr  out  ADDR_WIDTH  fetch address (current PC)
- ifetch_ready  in  1  memory accepts request when ifetch_req & ifetch_ready
- ifetch_data_valid  in  1  response strobe, in request order
- ifetch_data  in  INST_WIDTH  response data
- decode_stall  in  1  decode cannot take an instruction this cycle
- inst_valid  out  1  buffered instruction available
- inst_data  out  INST_WIDTH  instruction at buffer head
- inst_pc  out  ADDR_WIDTH  PC of buffer head
- flush_out  out  1  one-cycle pulse to squash younger pipeline stages

Behaviour:
- Reset (asynchronous, reset_n low):
  - pc=RESET_VECTOR, state=RESET, in_flight=0, discard=0, buffer empty.
  - All outputs are 0, except ifetch_addr=RESET_VECTOR.
- States:
  - RESET → FETCH on the first clock after reset_n deasserts. No request is issued in RESET.
  - FETCH: normal operation.
  - DRAIN: entered on a redirect when discards remain. Returns to FETCH in the cycle discard reaches 0.
- Credit rule: ifetch_req = (state==FETCH) & ~redirect_valid & (in_flight + buf_count < MAX_OUTSTANDING).
  - Requests may also issue in DRAIN once the new PC is loaded. Discards are tracked by count, not by state.
  - Correction: ifetch_req is asserted in FETCH or DRAIN.
  - ifetch_addr = pc.
- Accept (ifetch_req & ifetch_ready):
  - pc <= pc+2, wrapping modulo 2^ADDR_WIDTH.
  - in_flight++ and push the issuing pc into the PC tag FIFO.
- Response (ifetch_data_valid):
  - in_flight--.
  - If discard>0: discard--, pop and drop the tag.
  - Otherwise: pop the tag and write {tag, ifetch_data} into the instruction buffer.
  - Returned data is visible on inst_* the next cycle, so response-to-inst_valid latency is 1 cycle.
- Consume: inst_valid = buffer non-empty. Pop the head when inst_valid & ~decode_stall.
- Redirect (redirect_valid):
  - pc <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0}.
  - Instruction buffer cleared; flush_out=1 next cycle, for exactly one cycle.
  - discard <= in_flight minus any response consumed in the same cycle.
  - No request issues in the redirect cycle. Redirect wins over a simultaneous accept, because ifetch_req is gated low.
  - Redirect wins over a simultaneous consume: the popped entry is squashed and inst_valid goes to 0 next cycle.
- Back-to-back redirects: the second redirect overrides the first. discard is recomputed from the current in_flight.
- Full: no request is issued when credits are exhausted, so no response is ever dropped.
- Empty: inst_valid=0; inst_data and inst_pc hold their last values.
- Invariant: a response arriving with in_flight==0 is a protocol error. It is ignored; an assertion fires in simulation.
- Reset mid-operation: all state is cleared asynchronously. A response arriving before the first new request is ignored.

Decomposition:
- Shared package w0rm_core_pkg holds:
  - PC_INCREMENT=2
  - default RESET_VECTOR
  - state encoding localparams: RESET=0, FETCH=1, DRAIN=2
- One sub-module: w0rm_core_sync_fifo (parameterised width/depth, clear input, count output).
  - Instantiated twice: as the PC tag FIFO (ADDR_WIDTH) and as the instruction buffer (ADDR_WIDTH+INST_WIDTH), both depth MAX_OUTSTANDING.

Test Plan:
- Reset release, ifetch_ready=1, 1-cycle memory latency, no stall:
  - First ifetch_req with addr 0x0 one cycle after reset release.
  - Addresses 0x0, 0x2, 0x4… issued.
  - inst_pc tracks inst_data in order with no gaps.
- decode_stall held high for 10 cycles with MAX_OUTSTANDING=2:
  - Exactly 2 requests accepted, then ifetch_req=0.
  - On release, two instructions drain in order and fetching resumes.
- Redirect to 0x1001 while 2 requests are in flight:
  - flush_out pulses 1 cycle; inst_valid drops.
  - Next ifetch_addr=0x1000.
  - The two stale responses are discarded; the first valid inst_pc=0x1000.
- Redirect in the same cycle as ifetch_req & ifetch_ready and a response:
  - No accept occurs (pc not incremented past the old value).
  - discard = in_flight − 1.
  - Only post-redirect instructions reach decode.
- Redirects on consecutive cycles to 0x200 then 0x300:
  - The first fetched address is 0x300.
  - No instruction tagged 0x200 or older appears.
- PC at 0xFFFFFFFE accepted: the next ifetch_addr wraps to 0x0. Then assert reset_n low mid-stream: all outputs are 0 immediately, in the same cycle, without waiting for a clock edge.
